histo_window_sched: RTL and testbench

//  Sequences one histogram acquisition: opens a Collect window of programmed length, waits for the
//  CDC/split pipeline to drain, runs the frame/histogram read sweep, and captures the top-3 sort

---
 rtl/histo_window_sched.sv | 163 ++++++++++++++++
 tb/tb_histo_window_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_window_sched.sv
// Acquisition sequencer for the histogram datapath: collect window, drain, read sweep, sort capture, bin clear.
// Optional sorter watchdog enabled by defining SORT_TIMEOUT_EN.
module histo_window_sched #(
    parameter int DATA_SIZE    = 4,
    parameter int LENGTH       = 64,
    parameter int LENGTH_SIZE  = 6,
    parameter int WIN_W        = 16,
    parameter int DRAIN_CYC    = 20,
    parameter int SORT_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIN_W-1:0]           win_len,
    input  logic                       continuous,
    input  logic                       sort_valid,
    input  logic [3*DATA_SIZE-1:0]     sort_data,
    input  logic [3*LENGTH_SIZE-1:0]   sort_count,
    output logic                       collect,
    output logic                       rd_en,
    output logic [LENGTH_SIZE-1:0]     rd_addr,
    output logic                       his_rd_en,
    output logic [DATA_SIZE-1:0]       his_rd_addr,
    output logic                       clr_en,
    output logic [DATA_SIZE-1:0]       clr_addr,
    output logic                       busy,
    output logic                       res_valid,
    output logic [3*DATA_SIZE-1:0]     res_data,
    output logic [3*LENGTH_SIZE-1:0]   res_count,
    output logic                       done,
    output logic                       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_DRAIN, S_READ, S_WAIT_SORT, S_CLEAR, S_DONE
    } state_t;

`ifdef SORT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [WIN_W-1:0] ONE        = WIN_W'(1);
    localparam logic [WIN_W-1:0] DRAIN_LAST = WIN_W'(DRAIN_CYC - 1);
    localparam logic [WIN_W-1:0] READ_LAST  = WIN_W'(LENGTH - 1);
    localparam logic [WIN_W-1:0] NBINS      = WIN_W'(2 ** DATA_SIZE);
    localparam logic [WIN_W-1:0] CLEAR_LAST = WIN_W'((2 ** DATA_SIZE) - 1);
    localparam logic [WIN_W-1:0] TO_LAST    = WIN_W'(SORT_TIMEOUT - 1);

    state_t                     state_reg;
    logic [WIN_W-1:0]           cnt_reg;
    logic [WIN_W-1:0]           win_len_reg;
    logic                       res_valid_reg;
    logic [3*DATA_SIZE-1:0]     res_data_reg;
    logic [3*LENGTH_SIZE-1:0]   res_count_reg;
    logic                       err_reg;
    logic                       abortable;

    assign abortable = (state_reg == S_COLLECT) || (state_reg == S_DRAIN) ||
                       (state_reg == S_READ)    || (state_reg == S_WAIT_SORT);

    // One shared phase counter; every phase ends on its own terminal value so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            win_len_reg   <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_count_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            if (abortable && abort) begin
                state_reg <= S_CLEAR;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start && !abort && (win_len != '0)) begin
                            win_len_reg <= win_len;
                            cnt_reg     <= '0;
                            state_reg   <= S_COLLECT;
                        end
                    end
                    S_COLLECT: begin
                        if (cnt_reg == win_len_reg - ONE) begin
                            cnt_reg   <= '0;
                            state_reg <= S_DRAIN;
                        end else begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                    end
                    S_DRAIN: begin
                        if (cnt_reg == DRAIN_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= S_READ;
                        end else begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                    end
                    S_READ: begin
                        if (cnt_reg == READ_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= S_WAIT_SORT;
                        end else begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                    end
                    S_WAIT_SORT: begin
                        if (sort_valid) begin
                            res_data_reg  <= sort_data;
                            res_count_reg <= sort_count;
                            res_valid_reg <= 1'b1;
                            cnt_reg       <= '0;
                            state_reg     <= S_CLEAR;
                        end else if (TIMEOUT_EN && (cnt_reg == TO_LAST)) begin
                            err_reg   <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= S_CLEAR;
                        end else if (TIMEOUT_EN) begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                    end
                    S_CLEAR: begin
                        if (cnt_reg == CLEAR_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                    end
                    S_DONE: begin
                        cnt_reg   <= '0;
                        state_reg <= continuous ? S_COLLECT : S_IDLE;
                    end
                    default: begin
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Address outputs are forced to zero outside their phase so idle buses stay quiet.
    assign collect     = (state_reg == S_COLLECT);
    assign rd_en       = (state_reg == S_READ);
    assign rd_addr     = rd_en ? cnt_reg[LENGTH_SIZE-1:0] : '0;
    assign his_rd_en   = rd_en && (cnt_reg < NBINS);
    assign his_rd_addr = his_rd_en ? cnt_reg[DATA_SIZE-1:0] : '0;
    assign clr_en      = (state_reg == S_CLEAR);
    assign clr_addr    = clr_en ? cnt_reg[DATA_SIZE-1:0] : '0;
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign res_valid   = res_valid_reg;
    assign res_data    = res_data_reg;
    assign res_count   = res_count_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_histo_window_sched.sv
// Bench for histo_window_sched: per-cycle expected output frames are queued as stimulus is driven
// and compared at the falling edge; a table of acquisitions plus hand-written corner sequences.
module tb_histo_window_sched;

    localparam int P_C = 0, P_D = 1, P_R = 2, P_W = 3, P_CLR = 4, P_DONE = 5, P_IDLE = 6;
    localparam int DRAIN_N = 20, READ_N = 64, BINS = 16, TO_N = 64;
`ifdef SORT_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, abort, continuous, sort_valid;
    logic [15:0] win_len;
    logic [11:0] sort_data;
    logic [17:0] sort_count;
    logic        collect, rd_en, his_rd_en, clr_en, busy, res_valid, done, err_timeout;
    logic [5:0]  rd_addr;
    logic [3:0]  his_rd_addr, clr_addr;
    logic [11:0] res_data;
    logic [17:0] res_count;

    always #5 clk = ~clk;

    histo_window_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
        .continuous(continuous), .sort_valid(sort_valid), .sort_data(sort_data),
        .sort_count(sort_count), .collect(collect), .rd_en(rd_en), .rd_addr(rd_addr),
        .his_rd_en(his_rd_en), .his_rd_addr(his_rd_addr), .clr_en(clr_en), .clr_addr(clr_addr),
        .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_count(res_count),
        .done(done), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic        collect;
        logic        rd_en;
        logic [5:0]  rd_addr;
        logic        his_rd_en;
        logic [3:0]  his_rd_addr;
        logic        clr_en;
        logic [3:0]  clr_addr;
        logic        busy;
        logic        res_valid;
        logic [11:0] res_data;
        logic [17:0] res_count;
        logic        done;
        logic        err;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        start;
        logic        abort;
        logic        sort_valid;
        logic        continuous;
        logic [15:0] win_len;
        logic [11:0] sdata;
        logic [17:0] scount;
    } drive_t;

    typedef struct {
        int          win;
        int          loops;
        int          mid_win;
        int          sort_dly;
        logic [11:0] sdata;
        logic [17:0] scount;
        int          ab_ph;
        int          ab_n;
        int          poke_st;
        int          poke_sv;
        int          exp_len;
        int          exp_res;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e, mon_a;
    int          errors = 0;
    int          checks = 0;
    int          busy_cnt = 0;
    int          resv_cnt = 0;
    int          frame_no = 0;
    logic [11:0] m_res_data = '0;
    logic [17:0] m_res_count = '0;
    logic        m_err = 1'b0;
    vec_t        tbl[8];

    function automatic exp_t mk(input int p, input int n, input logic rv);
        exp_t f;
        f = '0;
        f.collect   = (p == P_C);
        f.rd_en     = (p == P_R);
        if (p == P_R) f.rd_addr = n[5:0];
        f.his_rd_en = (p == P_R) && (n < BINS);
        if (f.his_rd_en) f.his_rd_addr = n[3:0];
        f.clr_en    = (p == P_CLR);
        if (p == P_CLR) f.clr_addr = n[3:0];
        f.busy      = (p != P_IDLE);
        f.res_valid = rv;
        f.res_data  = m_res_data;
        f.res_count = m_res_count;
        f.done      = (p == P_DONE);
        f.err       = m_err;
        return f;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.collect = collect;     a.rd_en = rd_en;         a.rd_addr = rd_addr;
        a.his_rd_en = his_rd_en; a.his_rd_addr = his_rd_addr;
        a.clr_en = clr_en;       a.clr_addr = clr_addr;   a.busy = busy;
        a.res_valid = res_valid; a.res_data = res_data;   a.res_count = res_count;
        a.done = done;           a.err = err_timeout;
        return a;
    endfunction

    function automatic drive_t idle_d();
        drive_t d;
        d.rst = 1'b0; d.start = 1'b0; d.abort = 1'b0; d.sort_valid = 1'b0;
        d.continuous = 1'b0; d.win_len = '0; d.sdata = '0; d.scount = '0;
        return d;
    endfunction

    // Inputs applied here are sampled by the next rising edge; f is the output frame after that edge.
    task automatic step(input drive_t d, input exp_t f);
        @(negedge clk);
        #1;
        rst = d.rst; start = d.start; abort = d.abort; sort_valid = d.sort_valid;
        continuous = d.continuous; win_len = d.win_len; sort_data = d.sdata; sort_count = d.scount;
        exp_q.push_back(f);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = sample();
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL frame %0d: got %h want %h", frame_no, mon_a, mon_e);
            end
            if (busy === 1'b1) busy_cnt++;
            if (res_valid === 1'b1) resv_cnt++;
            frame_no++;
        end
    end

    task automatic run_acq(input int idx, input vec_t v);
        drive_t d;
        int p, n, pp, pn, loops_left, frames;
        logic rv;
        busy_cnt   = 0;
        resv_cnt   = 0;
        loops_left = v.loops;
        d = idle_d();
        d.start = 1'b1; d.win_len = 16'(v.win); d.sdata = v.sdata; d.scount = v.scount;
        p = P_C; n = 0;
        step(d, mk(p, n, 1'b0));
        frames = 1;
        while (p != P_IDLE && frames < 1000) begin
            d = idle_d();
            d.win_len    = 16'(v.mid_win);
            d.sdata      = v.sdata;
            d.scount     = v.scount;
            d.continuous = (loops_left > 1);
            pp = p; pn = n; rv = 1'b0;
            d.abort      = (pp == v.ab_ph) && (pn == v.ab_n);
            d.sort_valid = ((pp == P_W) && (pn == v.sort_dly)) || ((pp == P_R) && (pn == v.poke_sv));
            d.start      = (pp == P_D) && (pn == v.poke_st);
            if (d.abort && pp <= P_W) begin
                p = P_CLR; n = 0;
            end else begin
                case (pp)
                    P_C:    if (n == v.win - 1) begin p = P_D; n = 0; end else n++;
                    P_D:    if (n == DRAIN_N - 1) begin p = P_R; n = 0; end else n++;
                    P_R:    if (n == READ_N - 1) begin p = P_W; n = 0; end else n++;
                    P_W: begin
                        if (d.sort_valid) begin
                            p = P_CLR; n = 0; rv = 1'b1;
                            m_res_data = v.sdata; m_res_count = v.scount;
                        end else if (TO_ON && n == TO_N - 1) begin
                            p = P_CLR; n = 0; m_err = 1'b1;
                        end else begin
                            n++;
                        end
                    end
                    P_CLR:  if (n == BINS - 1) begin p = P_DONE; n = 0; end else n++;
                    P_DONE: if (d.continuous) begin p = P_C; n = 0; loops_left--; end else p = P_IDLE;
                    default: p = P_IDLE;
                endcase
            end
            step(d, mk(p, n, rv));
            frames++;
        end
        checks++;
        if (frames >= 1000) begin
            errors++;
            $display("FAIL acq%0d_bound: model still busy after %0d frames, required idle", idx, frames);
        end
        step(idle_d(), mk(P_IDLE, 0, 1'b0));
        step(idle_d(), mk(P_IDLE, 0, 1'b0));
        @(negedge clk);
        #1;
        checks++;
        if (busy_cnt != v.exp_len) begin
            errors++;
            $display("FAIL acq%0d_busy_len: got %0d want %0d", idx, busy_cnt, v.exp_len);
        end
        checks++;
        if (resv_cnt != v.exp_res) begin
            errors++;
            $display("FAIL acq%0d_res_valid: got %0d want %0d", idx, resv_cnt, v.exp_res);
        end
        $display("acq %0d: win=%0d loops=%0d busy=%0d res_valid=%0d res_data=%h err=%b",
                 idx, v.win, v.loops, busy_cnt, resv_cnt, res_data, err_timeout);
    endtask

    initial begin
        drive_t d;
        vec_t   tv;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sort_valid = 1'b0; continuous = 1'b0;
        win_len = '0; sort_data = '0; sort_count = '0;

        //          win loops mid sdly sdata    scount                       ab_ph  ab_n pst psv len res
        tbl[0] = '{5,  1,  5,  3, 12'h397, {6'd4, 6'd8, 6'd12},       -1,   -1, -1, -1, 110, 1};
        tbl[1] = '{3,  2,  9,  0, 12'h5a1, {6'd33, 6'd2, 6'd63},      -1,   -1, -1, -1, 210, 2};
        tbl[2] = '{5,  1,  5,  3, 12'hfff, {6'd1, 6'd1, 6'd1},        P_R,  10, -1, -1, 53,  0};
        tbl[3] = '{2,  1,  2,  3, 12'h123, {6'd5, 6'd6, 6'd7},        P_C,  0,  -1, -1, 18,  0};
        tbl[4] = '{4,  1,  4,  5, 12'h456, {6'd9, 6'd10, 6'd11},      P_W,  2,  -1, -1, 108, 0};
        tbl[5] = '{1,  1,  1,  1, 12'h0e2, {6'd17, 6'd40, 6'd60},     P_CLR, 3, 5,  7,  104, 1};
        tbl[6] = '{2,  1,  7,  0, 12'hc3c, {6'd21, 6'd42, 6'd0},      P_DONE, 0, -1, -1, 104, 1};
        tbl[7] = '{6,  1,  6,  3, 12'h777, {6'd3, 6'd3, 6'd3},        P_D,  19, -1, -1, 43,  0};

        d = idle_d();
        d.rst = 1'b1;
        repeat (3) step(d, mk(P_IDLE, 0, 1'b0));
        d.rst = 1'b0;
        repeat (2) step(d, mk(P_IDLE, 0, 1'b0));

        for (int i = 0; i < 8; i++) run_acq(i, tbl[i]);

        // start with a zero window, abort+start together, sort_valid while idle: all ignored
        d = idle_d(); d.start = 1'b1; d.win_len = 16'd0;
        step(d, mk(P_IDLE, 0, 1'b0));
        d = idle_d(); d.start = 1'b1; d.abort = 1'b1; d.win_len = 16'd5;
        step(d, mk(P_IDLE, 0, 1'b0));
        d = idle_d(); d.sort_valid = 1'b1; d.sdata = 12'habc; d.scount = 18'h2aaaa;
        step(d, mk(P_IDLE, 0, 1'b0));
        step(idle_d(), mk(P_IDLE, 0, 1'b0));
        $display("seq idle_ignores: res_data=%h busy=%b", res_data, busy);

        if (TO_ON) begin
            tv = '{2, 1, 2, -1, 12'h999, {6'd9, 6'd9, 6'd9}, -1, -1, -1, -1, 167, 0};
            run_acq(8, tv);
            run_acq(9, tbl[0]);
        end

        // reset mid-collect: immediate return to idle with results and error flag cleared
        d = idle_d(); d.start = 1'b1; d.win_len = 16'd8;
        step(d, mk(P_C, 0, 1'b0));
        for (int i = 1; i < 4; i++) step(idle_d(), mk(P_C, i, 1'b0));
        m_res_data = '0; m_res_count = '0; m_err = 1'b0;
        d = idle_d(); d.rst = 1'b1;
        step(d, mk(P_IDLE, 0, 1'b0));
        step(idle_d(), mk(P_IDLE, 0, 1'b0));
        step(idle_d(), mk(P_IDLE, 0, 1'b0));
        @(negedge clk);
        #1;
        $display("seq reset_mid_op: busy=%b res_data=%h err=%b", busy, res_data, err_timeout);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
